plot_receiver: RTL and testbench
================================

# plot_receiver

Receiving end of the pixel-plot interface (x, y, colour, plot) that the drawing datapaths drive. It clips off-screen coordinates, converts each in-range plot into a linear 160x120 framebuffer address, and buffers requests in a small FIFO. It drains the FIFO to a framebuffer write port using a valid/ready handshake. It sits between the movement/firing datapaths and the framebuffer memory, so drawing logic never stalls on memory arbitration.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- WIDTH, 160, screen width in pixels; valid x is 0..WIDTH-1
- HEIGHT, 120, screen height in pixels; valid y is 0..HEIGHT-1
- clk  in  1  system clock, 50 MHz; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- x  in  8  plot column
- y  in  7  plot row
- colour  in  24  plot colour, 8 bits per channel, R in [23:16]
- plot  in  1  single-cycle write strobe; one pixel per high cycle
- busy  out  1  FIFO full; a plot seen in this cycle is dropped
- fb_addr  out  15  head-entry address, y*WIDTH + x
- fb_colour  out  24  head-entry colour
- fb_we  out  1  head entry valid (FIFO non-empty)
- fb_ready  in  1  framebuffer accepts the head entry this cycle
- clipped  out  8  saturating count of plots rejected as off-screen
- overflow  out  8  saturating count of in-range plots dropped because busy was high

## Operation
- Clip check: a plot with x >= WIDTH or y >= HEIGHT is rejected. clipped increments (saturates at 255) and nothing is enqueued. The clip check takes priority over the full check; an off-screen plot while full counts only as clipped.
- Address: y*WIDTH + x, computed combinationally at the input from shifts and adds (for 160: (y<<7)+(y<<5)+x), 15-bit result, stored in the FIFO with colour. No multiplier.
- Push: plot=1, in range, busy=0 -> entry written at the tail, tail pointer +1 mod DEPTH.
- Drop: plot=1, in range, busy=1 -> overflow increments (saturates at 255) and the FIFO is unchanged. A pop in the same cycle does not free the slot for this plot.
- Pop: fb_we=1 and fb_ready=1 -> head pointer +1 mod DEPTH.
- Head entry: fb_addr and fb_colour show the head entry whenever fb_we=1 (show-ahead). They hold stable while fb_we=1 and fb_ready=0.
- Simultaneous push and pop when not full: occupancy unchanged, both pointers advance.
- Occupancy counter is 0..DEPTH; busy = (count == DEPTH), fb_we = (count != 0).
- Order is strictly FIFO; no write coalescing.
- fb_addr and fb_colour are don't-care when fb_we=0 and must not be checked.

## Timing
- Reset (reset=1 at an edge) forces the following values from the next cycle:
  - fb_we=0, busy=0, clipped=0, overflow=0, fb_addr=0, fb_colour=0.
  - Occupancy and both pointers are 0.
- Reset takes priority over a plot or pop in the same cycle. Reset mid-drain discards all pending entries.
- Latency: a plot accepted at edge N gives fb_we=1 with that entry in the cycle after edge N, when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained. With fb_ready held high, the FIFO never fills.
- busy, fb_we and the counters are registered or derived only from registered state. No combinational path from plot or fb_ready to any output.
- Pointer wrap: after DEPTH pushes, the tail returns to 0 with no loss of the entry in slot 0.

## Test plan
- Reset, then plot x=3 y=2 colour=0xFF0000 with fb_ready=1 -> the next cycle shows fb_we=1, fb_addr=323, fb_colour=0xFF0000; the cycle after shows fb_we=0.
- Plot x=160 y=0, then x=0 y=120 -> no fb_we, clipped=2, overflow=0.
- fb_ready=0, five in-range plots on consecutive cycles:
  - busy=1 after the 4th.
  - The 5th is dropped: overflow=1.
  - Then fb_ready=1 -> exactly 4 writes in push order over 4 cycles, then busy=0 and fb_we=0.
- fb_ready held high with 10 consecutive plots (x=0..9, y=119) -> fb_addr = 19040..19049 in order, busy never asserts, and pointers wrap correctly.
- 300 off-screen plots -> clipped saturates at 255. 300 dropped plots while full -> overflow saturates at 255.
- 3 entries queued with fb_ready=0, then reset=1 for one cycle together with a plot -> fb_we=0 and all counters 0 afterward, and the plot is not enqueued.

Source files
------------

// File: rtl/plot_receiver_if.sv
// Pixel-plot request bus and framebuffer write port shared by the drawing
// datapaths (master) and the plot receiver (slave).
interface plot_receiver_if;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [23:0] colour;
  logic        plot;
  logic        busy;
  logic [14:0] fb_addr;
  logic [23:0] fb_colour;
  logic        fb_we;
  logic        fb_ready;

  modport master (
    output x, y, colour, plot, fb_ready,
    input  busy, fb_addr, fb_colour, fb_we
  );

  modport slave (
    input  x, y, colour, plot, fb_ready,
    output busy, fb_addr, fb_colour, fb_we
  );
endinterface

// File: rtl/plot_receiver.sv
// Clips plot requests to the screen, turns them into linear framebuffer
// addresses and queues them in a show-ahead FIFO drained by fb_ready.
module plot_receiver #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic            clk,
  input  logic            reset,
  plot_receiver_if.slave  pif,
  output logic [7:0]      clipped_o,
  output logic [7:0]      overflow_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam logic [8:0]    WidthX  = 9'(WIDTH);
  localparam logic [7:0]    HeightY = 8'(HEIGHT);
  localparam logic [14:0]   WidthA  = 15'(WIDTH);
  localparam logic [PtrW:0] DepthC  = (PtrW + 1)'(DEPTH);

  typedef struct packed {
    logic [14:0] addr;
    logic [23:0] colour;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          headEntry;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW:0]   count_q, count_d;
  logic [7:0]      clipped_q, clipped_d;
  logic [7:0]      overflow_q, overflow_d;
  logic [14:0]     linAddr;
  logic            inRange, full, empty;
  logic            clipEv, pushEn, dropEv, popEn;

  // y*WIDTH as a sum of shifted copies of y, one per set bit of WIDTH
  always_comb begin
    linAddr = {7'd0, pif.x};
    for (int k = 0; k < 15; k++) begin
      if (WidthA[k]) linAddr = linAddr + ({8'd0, pif.y} << k);
    end
  end

  assign inRange = ({1'b0, pif.x} < WidthX) && ({1'b0, pif.y} < HeightY);
  assign full    = (count_q == DepthC);
  assign empty   = (count_q == '0);
  assign clipEv  = pif.plot && !inRange;
  assign pushEn  = pif.plot && inRange && !full;
  assign dropEv  = pif.plot && inRange && full;
  assign popEn   = !empty && pif.fb_ready;

  always_comb begin
    head_d     = popEn  ? head_q + 1'b1 : head_q;
    tail_d     = pushEn ? tail_q + 1'b1 : tail_q;
    count_d    = count_q;
    case ({pushEn, popEn})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    clipped_d  = (clipEv && clipped_q != 8'hFF) ? clipped_q + 8'd1 : clipped_q;
    overflow_d = (dropEv && overflow_q != 8'hFF) ? overflow_q + 8'd1 : overflow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      clipped_q  <= '0;
      overflow_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      clipped_q  <= clipped_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (pushEn && !reset) mem_q[tail_q] <= '{addr: linAddr, colour: pif.colour};
  end

  assign headEntry     = mem_q[head_q];
  assign pif.busy      = full;
  assign pif.fb_we     = !empty;
  assign pif.fb_addr   = empty ? 15'd0 : headEntry.addr;
  assign pif.fb_colour = empty ? 24'd0 : headEntry.colour;
  assign clipped_o     = clipped_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_plot_receiver.sv
// Scoreboard bench for plot_receiver: directed plots queue expected writes,
// a negedge monitor pops and compares every framebuffer write.
module tb_plot_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] clipped, overflow;

  plot_receiver_if pif ();

  plot_receiver #(.DEPTH(4), .WIDTH(160), .HEIGHT(120)) dut (
    .clk        (clk),
    .reset      (reset),
    .pif        (pif),
    .clipped_o  (clipped),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic [23:0] colour;
  } exp_t;

  exp_t sbQ [$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   writeCount = 0;
  int   writeSnap;
  bit   busySeen   = 1'b0;

  logic [7:0]  t3X    [5] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
  logic [6:0]  t3Y    [5] = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4};
  logic [14:0] t3Addr [5] = '{15'd10, 15'd171, 15'd332, 15'd493, 15'd654};
  logic [23:0] t3Col  [5] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC, 24'hDDEEFF};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One plot cycle; an accepted plot is recorded on the scoreboard
  task automatic applyStimulus(input logic [7:0] xv, input logic [6:0] yv, input logic [23:0] cv,
                               input bit expAccept, input logic [14:0] expAddr);
    exp_t e;
    pif.x      = xv;
    pif.y      = yv;
    pif.colour = cv;
    pif.plot   = 1'b1;
    if (expAccept) begin
      e.addr   = expAddr;
      e.colour = cv;
      sbQ.push_back(e);
    end
    @(posedge clk);
    #1;
    pif.plot = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      if (pif.busy === 1'b1) busySeen = 1'b1;
      if (pif.fb_we === 1'b1 && pif.fb_ready === 1'b1) begin
        writeCount++;
        if (sbQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpectedWrite: got write addr %0d, expected no write", pif.fb_addr);
        end else begin
          e = sbQ.pop_front();
          checkOutput("writeAddr", 32'(pif.fb_addr), 32'(e.addr));
          checkOutput("writeColour", 32'(pif.fb_colour), 32'(e.colour));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    pif.plot     = 1'b0;
    pif.x        = '0;
    pif.y        = '0;
    pif.colour   = '0;
    pif.fb_ready = 1'b0;
    waitCycles(2);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rstFbWe", 32'(pif.fb_we), 0);
    checkOutput("rstBusy", 32'(pif.busy), 0);
    checkOutput("rstClipped", 32'(clipped), 0);
    checkOutput("rstOverflow", 32'(overflow), 0);
    checkOutput("rstFbAddr", 32'(pif.fb_addr), 0);
    checkOutput("rstFbColour", 32'(pif.fb_colour), 0);

    $display("[TB] single plot latency");
    pif.fb_ready = 1'b1;
    applyStimulus(8'd3, 7'd2, 24'hFF0000, 1'b1, 15'd323);
    checkOutput("latFbWe", 32'(pif.fb_we), 1);
    checkOutput("latFbAddr", 32'(pif.fb_addr), 323);
    waitCycles(1);
    checkOutput("latFbWeAfter", 32'(pif.fb_we), 0);

    $display("[TB] clipping");
    applyStimulus(8'd160, 7'd0, 24'h00FF00, 1'b0, 15'd0);
    applyStimulus(8'd0, 7'd120, 24'h00FF00, 1'b0, 15'd0);
    checkOutput("clipFbWe", 32'(pif.fb_we), 0);
    checkOutput("clipCount", 32'(clipped), 2);
    checkOutput("clipOverflow", 32'(overflow), 0);

    $display("[TB] fill and drop");
    pif.fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(t3X[i], t3Y[i], t3Col[i], i < 4, t3Addr[i]);
      if (i == 3) checkOutput("fullBusy", 32'(pif.busy), 1);
    end
    checkOutput("dropOverflow", 32'(overflow), 1);
    applyStimulus(8'd200, 7'd5, 24'h123456, 1'b0, 15'd0);
    checkOutput("clipWhileFull", 32'(clipped), 3);
    checkOutput("clipWhileFullOvf", 32'(overflow), 1);
    checkOutput("holdFbAddr", 32'(pif.fb_addr), 10);
    checkOutput("holdFbColour", 32'(pif.fb_colour), 32'h112233);
    pif.fb_ready = 1'b1;
    waitCycles(4);
    checkOutput("drainBusy", 32'(pif.busy), 0);
    checkOutput("drainFbWe", 32'(pif.fb_we), 0);
    checkOutput("drainSbEmpty", sbQ.size(), 0);

    $display("[TB] streaming with pointer wrap");
    busySeen = 1'b0;
    for (int i = 0; i < 10; i++)
      applyStimulus(8'(i), 7'd119, 24'h0000A0 + 24'(i), 1'b1, 15'd19040 + 15'(i));
    waitCycles(1);
    checkOutput("streamBusySeen", 32'(busySeen), 0);
    checkOutput("streamFbWe", 32'(pif.fb_we), 0);
    checkOutput("streamSbEmpty", sbQ.size(), 0);

    $display("[TB] counter saturation");
    for (int i = 0; i < 300; i++) applyStimulus(8'd200, 7'd5, 24'h0, 1'b0, 15'd0);
    checkOutput("clipSaturate", 32'(clipped), 255);
    pif.fb_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(8'(i), 7'd0, 24'h0000FF, 1'b1, 15'(i));
    for (int i = 0; i < 300; i++) applyStimulus(8'd5, 7'd5, 24'hFFFFFF, 1'b0, 15'd0);
    checkOutput("ovfSaturate", 32'(overflow), 255);
    checkOutput("ovfBusy", 32'(pif.busy), 1);
    pif.fb_ready = 1'b1;
    waitCycles(4);
    checkOutput("satDrainFbWe", 32'(pif.fb_we), 0);
    pif.fb_ready = 1'b0;

    $display("[TB] reset mid-drain");
    for (int i = 0; i < 3; i++) applyStimulus(8'(i), 7'd1, 24'h0F0F0F, 1'b1, 15'd160 + 15'(i));
    checkOutput("preRstFbWe", 32'(pif.fb_we), 1);
    reset      = 1'b1;
    pif.x      = 8'd1;
    pif.y      = 7'd1;
    pif.colour = 24'hABCDEF;
    pif.plot   = 1'b1;
    sbQ.delete();
    waitCycles(1);
    reset    = 1'b0;
    pif.plot = 1'b0;
    checkOutput("midRstFbWe", 32'(pif.fb_we), 0);
    checkOutput("midRstBusy", 32'(pif.busy), 0);
    checkOutput("midRstClipped", 32'(clipped), 0);
    checkOutput("midRstOverflow", 32'(overflow), 0);
    writeSnap    = writeCount;
    pif.fb_ready = 1'b1;
    waitCycles(3);
    checkOutput("midRstNoWrites", 32'(writeCount - writeSnap), 0);
    checkOutput("midRstFbWeLater", 32'(pif.fb_we), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
